// File: rtl/apb4_completer_mem_if.sv
// APB4 bus bundle between a requester (master modport) and the completer memory (slave modport).
interface apb4_completer_mem_if #(
  parameter int AddressWidth = 12,
  parameter int DataWidth    = 32
);
  logic [AddressWidth-1:0]  paddr;
  logic                     pwrite;
  logic                     psel;
  logic                     penable;
  logic [DataWidth-1:0]     pwdata;
  logic [DataWidth/8-1:0]   pstrb;
  logic [DataWidth-1:0]     prdata;
  logic                     pready;
  logic                     pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_completer_mem.sv
// APB4 completer memory with byte strobes and a fixed wait-state count.
// Define APB4_COMPLETER_MEM_PSLVERR_EN to flag out-of-range accesses with pslverr instead of wrapping.
module apb4_completer_mem #(
  parameter int AddressWidth = 12,
  parameter int DataWidth    = 32,
  parameter int MemoryDepth  = 256,
  parameter int WaitStates   = 2
) (
  input  logic                clk,
  input  logic                rst,
  apb4_completer_mem_if.slave bus
);
  localparam int  StrbW       = DataWidth / 8;
  localparam int  OffW        = $clog2(StrbW);
  localparam int  IdxW        = AddressWidth - OffW;
  localparam int  MemAw       = (MemoryDepth > 1) ? $clog2(MemoryDepth) : 1;
  localparam int  CntW        = (WaitStates > 1) ? $clog2(WaitStates) : 1;
  localparam bit  DepthIsPow2 = (MemoryDepth & (MemoryDepth - 1)) == 0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [MemAw-1:0]     idx_q, idx_d;
  logic                 write_q, write_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]     strb_q, strb_d;
  logic                 err_q, err_d;
  logic                 pready_q, pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [DataWidth-1:0] prdata_q, prdata_d;
  logic [DataWidth-1:0] mem_q [MemoryDepth];

  logic [IdxW-1:0]  raw_idx;
  logic [MemAw-1:0] raw_eff;
  logic             raw_err;
  logic             mem_we;
  logic             go_ready;
  logic [MemAw-1:0] src_idx;
  logic             src_write;
  logic             src_err;

  assign raw_idx = bus.paddr[AddressWidth-1:OffW];

  if (OffW > 0) begin : g_lsb
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.paddr[OffW-1:0];
  end

  // Map the word index onto storage: in range passes through, out of range errors or wraps.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    raw_err = 1'b0;
    raw_eff = raw_idx[MemAw-1:0];
    if (32'(raw_idx) >= MemoryDepth) begin
`ifdef APB4_COMPLETER_MEM_PSLVERR_EN
      raw_err = 1'b1;
      raw_eff = '0;
`else
      raw_eff = DepthIsPow2 ? MemAw'(raw_idx & IdxW'(MemoryDepth - 1))
                            : MemAw'(MemoryDepth - 1);
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    mem_we    = 1'b0;
    go_ready  = 1'b0;
    src_idx   = idx_q;
    src_write = write_q;
    src_err   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.psel && !bus.penable) begin
          idx_d   = raw_eff;
          write_d = bus.pwrite;
          wdata_d = bus.pwdata;
          strb_d  = bus.pstrb;
          err_d   = raw_err;
          if (WaitStates == 0) begin
            // Zero-wait: the setup edge itself loads the response, so bypass the latches.
            state_d   = S_READY;
            go_ready  = 1'b1;
            src_idx   = raw_eff;
            src_write = bus.pwrite;
            src_err   = raw_err;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CntW'(WaitStates - 1);
          end
        end
      end
      S_WAIT: begin
        if (!bus.psel) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d  = S_READY;
          go_ready = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      S_READY: begin
        state_d = S_IDLE;
        mem_we  = bus.psel && bus.penable && write_q && !err_q && !rst;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_ready) begin
      pready_d  = 1'b1;
      pslverr_d = src_err;
      if (!src_write && !src_err) prdata_d = mem_q[src_idx];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // NOTE: the storage array has no reset; contents survive rst and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < StrbW; k++) begin
        if (strb_q[k]) mem_q[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;
endmodule

// File: tb/tb_apb4_completer_mem.sv
// Bench for apb4_completer_mem: two instances (2 wait states / depth 256, 0 wait states / depth 200)
// driven from one requester, checked against a word-array reference model.
module tb_apb4_completer_mem;
  localparam int AW      = 12;
  localparam int DW      = 32;
  localparam int DEPTH_A = 256;
  localparam int WS_A    = 2;
  localparam int DEPTH_B = 200;
  localparam int WS_B    = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] paddr   = '0;
  logic          pwrite  = 1'b0;
  logic          psel    = 1'b0;
  logic          penable = 1'b0;
  logic [DW-1:0] pwdata  = '0;
  logic [3:0]    pstrb   = '0;
  int            tb_sel  = 0;

  apb4_completer_mem_if #(.AddressWidth(AW), .DataWidth(DW)) bus_a ();
  apb4_completer_mem_if #(.AddressWidth(AW), .DataWidth(DW)) bus_b ();

  assign bus_a.paddr   = paddr;
  assign bus_a.pwrite  = pwrite;
  assign bus_a.psel    = psel && (tb_sel == 0);
  assign bus_a.penable = penable;
  assign bus_a.pwdata  = pwdata;
  assign bus_a.pstrb   = pstrb;
  assign bus_b.paddr   = paddr;
  assign bus_b.pwrite  = pwrite;
  assign bus_b.psel    = psel && (tb_sel == 1);
  assign bus_b.penable = penable;
  assign bus_b.pwdata  = pwdata;
  assign bus_b.pstrb   = pstrb;

  logic          cur_pready, cur_pslverr;
  logic [DW-1:0] cur_prdata;
  assign cur_pready  = (tb_sel == 1) ? bus_b.pready  : bus_a.pready;
  assign cur_pslverr = (tb_sel == 1) ? bus_b.pslverr : bus_a.pslverr;
  assign cur_prdata  = (tb_sel == 1) ? bus_b.prdata  : bus_a.prdata;

  apb4_completer_mem #(
    .AddressWidth(AW), .DataWidth(DW), .MemoryDepth(DEPTH_A), .WaitStates(WS_A)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a.slave)
  );

  apb4_completer_mem #(
    .AddressWidth(AW), .DataWidth(DW), .MemoryDepth(DEPTH_B), .WaitStates(WS_B)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one word array per instance, indexed by word number.
  logic [31:0] mdl_a [DEPTH_A];
  logic [31:0] mdl_b [DEPTH_B];

  function automatic int depth_of(input int sel);
    return (sel == 1) ? DEPTH_B : DEPTH_A;
  endfunction

  function automatic int ws_of(input int sel);
    return (sel == 1) ? WS_B : WS_A;
  endfunction

  function automatic void map_addr(input int sel, input logic [AW-1:0] addr,
                                   output int idx, output bit err);
    int raw = int'(addr) / 4;
    int d   = depth_of(sel);
    err = 1'b0;
    idx = raw;
    if (raw >= d) begin
`ifdef APB4_COMPLETER_MEM_PSLVERR_EN
      err = 1'b1;
      idx = 0;
`else
      idx = ((d & (d - 1)) == 0) ? (raw % d) : (d - 1);
`endif
    end
  endfunction

  function automatic logic [31:0] mdl_get(input int sel, input int idx);
    return (sel == 1) ? mdl_b[idx] : mdl_a[idx];
  endfunction

  function automatic void mdl_put(input int sel, input int idx, input logic [31:0] wd,
                                  input logic [3:0] sb);
    logic [31:0] w = mdl_get(sel, idx);
    for (int k = 0; k < 4; k++) if (sb[k]) w[8*k +: 8] = wd[8*k +: 8];
    if (sel == 1) mdl_b[idx] = w;
    else          mdl_a[idx] = w;
  endfunction

  // One full transfer; leaves psel/penable high so the next edge is the completing edge.
  task automatic xfer(input int sel, input logic [AW-1:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [3:0] sb, input string tag,
                      output logic [31:0] rd);
    int          cyc;
    int          idx;
    bit          err;
    logic [31:0] exp_rd;
    @(posedge clk); #1;
    tb_sel = sel; psel = 1'b1; penable = 1'b0;
    paddr = addr; pwrite = wr; pwdata = wd; pstrb = sb;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 1;
    while (cur_pready !== 1'b1 && cyc < 20) begin
      check({tag, "_wait_outputs"}, {31'd0, cur_pslverr, cur_prdata}, 64'd0);
      @(posedge clk); #1;
      cyc++;
    end
    map_addr(sel, addr, idx, err);
    check({tag, "_latency"}, 64'(cyc), 64'(1 + ws_of(sel)));
    check({tag, "_pslverr"}, 64'(cur_pslverr), 64'(err));
    rd = cur_prdata;
    if (!wr) begin
      exp_rd = err ? 32'd0 : mdl_get(sel, idx);
      check({tag, "_prdata"}, 64'(cur_prdata), 64'(exp_rd));
    end else if (!err) begin
      mdl_put(sel, idx, wd, sb);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    check("pready_single_cycle", 64'(cur_pready), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] old;
    int          idx;
    bit          err;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pready_a",  64'(bus_a.pready),  64'd0);
    check("rst_pslverr_a", 64'(bus_a.pslverr), 64'd0);
    check("rst_prdata_a",  64'(bus_a.prdata),  64'd0);
    check("rst_pready_b",  64'(bus_b.pready),  64'd0);
    check("rst_prdata_b",  64'(bus_b.prdata),  64'd0);
    rst = 1'b0;

    // Fill both memories so every later read has a defined expectation.
    for (int i = 0; i < DEPTH_A; i++) xfer(0, AW'(i * 4), 1'b1, $urandom, 4'hF, "init_a", rd);
    for (int i = 0; i < DEPTH_B; i++) xfer(1, AW'(i * 4), 1'b1, $urandom, 4'hF, "init_b", rd);
    go_idle();

    xfer(0, 12'h010, 1'b1, 32'hDEADBEEF, 4'hF, "t1_wr", rd);
    xfer(0, 12'h010, 1'b0, 32'h0, 4'h0, "t1_rd", rd);
    check("t1_value", 64'(rd), 64'h0DEADBEEF);
    go_idle();

    xfer(0, 12'h020, 1'b1, 32'h11223344, 4'hF, "t2_wr_full", rd);
    xfer(0, 12'h020, 1'b1, 32'hAABBCCDD, 4'h5, "t2_wr_part", rd);
    xfer(0, 12'h020, 1'b0, 32'h0, 4'hF, "t2_rd", rd);
    check("t2_value", 64'(rd), 64'h11BB33DD);
    xfer(0, 12'h020, 1'b1, 32'hFFFFFFFF, 4'h0, "t2_wr_nostrb", rd);
    xfer(0, 12'h020, 1'b0, 32'h0, 4'h0, "t2_rd_nostrb", rd);
    check("t2_value_nostrb", 64'(rd), 64'h11BB33DD);
    go_idle();

    xfer(1, 12'h004, 1'b1, 32'h0000CAFE, 4'hF, "t3_wr", rd);
    xfer(1, 12'h004, 1'b0, 32'h0, 4'h0, "t3_rd", rd);
    check("t3_value", 64'(rd), 64'h0000CAFE);
    go_idle();

    xfer(0, 12'h400, 1'b0, 32'h0, 4'h0, "t4_rd_oor", rd);
    xfer(0, 12'h400, 1'b1, 32'h12345678, 4'hF, "t4_wr_oor", rd);
    xfer(0, 12'h000, 1'b0, 32'h0, 4'h0, "t4_rd_0", rd);
`ifndef APB4_COMPLETER_MEM_PSLVERR_EN
    check("t4_wrap_value", 64'(rd), 64'h12345678);
`endif
    xfer(1, 12'h400, 1'b1, 32'h0BADF00D, 4'hF, "t4_wr_oor_b", rd);
    xfer(1, 12'h31C, 1'b0, 32'h0, 4'h0, "t4_rd_last_b", rd);
    go_idle();

    // Abort: psel dropped while the write is still waiting.
    map_addr(0, 12'h008, idx, err);
    old = mdl_get(0, idx);
    @(posedge clk); #1;
    tb_sel = 0; psel = 1'b1; penable = 1'b0;
    paddr = 12'h008; pwrite = 1'b1; pwdata = 32'h5555AAAA; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    check("abort_wait_pready", 64'(cur_pready), 64'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_pready", 64'(cur_pready), 64'd0);
    end
    xfer(0, 12'h008, 1'b0, 32'h0, 4'h0, "abort_rd", rd);
    check("abort_old_value", 64'(rd), 64'(old));

    // Reset while waiting.
    @(posedge clk); #1;
    tb_sel = 0; psel = 1'b1; penable = 1'b0;
    paddr = 12'h008; pwrite = 1'b1; pwdata = 32'h5555AAAA; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_wait_pready", 64'(cur_pready), 64'd0);
    check("rst_wait_prdata", 64'(cur_prdata), 64'd0);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer(0, 12'h008, 1'b0, 32'h0, 4'h0, "rst_wait_rd", rd);
    check("rst_wait_old_value", 64'(rd), 64'(old));

    // Reset on the completing edge of a zero-wait write discards it.
    map_addr(1, 12'h008, idx, err);
    old = mdl_get(1, idx);
    @(posedge clk); #1;
    tb_sel = 1; psel = 1'b1; penable = 1'b0;
    paddr = 12'h008; pwrite = 1'b1; pwdata = 32'h77778888; pstrb = 4'hF;
    @(posedge clk); #1;
    check("rst_ready_pready", 64'(cur_pready), 64'd1);
    penable = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_pready_low", 64'(cur_pready), 64'd0);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer(1, 12'h008, 1'b0, 32'h0, 4'h0, "rst_ready_rd", rd);
    check("rst_ready_old_value", 64'(rd), 64'(old));
    go_idle();

    xfer(0, 12'h00C, 1'b1, 32'h01020304, 4'hF, "t6_wr", rd);
    xfer(0, 12'h00E, 1'b0, 32'h0, 4'h0, "t6_rd", rd);
    check("t6_value", 64'(rd), 64'h01020304);
    go_idle();

    for (int n = 0; n < 400; n++) begin
      int          sel = int'($urandom_range(0, 1));
      logic [AW-1:0] addr;
      if ($urandom_range(0, 7) == 0) addr = AW'($urandom_range(0, 4095));
      else addr = AW'($urandom_range(0, depth_of(sel) * 4 - 1));
      xfer(sel, addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), "rand", rd);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
